// File: rtl/xif_result_sequencer_if.sv
// Signal bundle between the coprocessor result ports, the issue tracker and the core result port.
// The slave modport is the sequencer's view; master is the surrounding tile (or a bench).
interface xif_result_sequencer_if #(
    parameter int N_COPROC    = 2,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int IDX_W       = (N_COPROC > 1) ? $clog2(N_COPROC) : 1,
    parameter int CNT_W       = $clog2(DEPTH + 1)
);
    // valid/ready: a transfer happens in a cycle where both valid and ready are high;
    // valid never depends combinationally on ready, and payload is held while valid && !ready.
    logic                            track_valid_i;
    logic [IDX_W-1:0]                track_coproc_i;
    logic [X_ID_WIDTH-1:0]           track_id_i;
    logic                            track_ready_o;

    logic [N_COPROC-1:0]             coproc_result_valid_i;
    logic [N_COPROC-1:0]             coproc_result_ready_o;
    logic [N_COPROC*X_ID_WIDTH-1:0]  coproc_result_id_i;
    logic [N_COPROC*X_RFW_WIDTH-1:0] coproc_result_data_i;
    logic [N_COPROC*5-1:0]           coproc_result_rd_i;
    logic [N_COPROC-1:0]             coproc_result_we_i;
    logic [N_COPROC-1:0]             coproc_result_exc_i;
    logic [N_COPROC*6-1:0]           coproc_result_exccode_i;

    logic                            result_valid_o;
    logic                            result_ready_i;
    logic [X_ID_WIDTH-1:0]           result_id_o;
    logic [X_RFW_WIDTH-1:0]          result_data_o;
    logic [4:0]                      result_rd_o;
    logic                            result_we_o;
    logic                            result_exc_o;
    logic [5:0]                      result_exccode_o;

    logic [CNT_W-1:0]                outstanding_o;
    logic [1:0]                      err_o;

    modport slave (
        input  track_valid_i, track_coproc_i, track_id_i,
        output track_ready_o,
        input  coproc_result_valid_i, coproc_result_id_i, coproc_result_data_i,
        input  coproc_result_rd_i, coproc_result_we_i, coproc_result_exc_i, coproc_result_exccode_i,
        output coproc_result_ready_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o,
        output result_we_o, result_exc_o, result_exccode_o,
        input  result_ready_i,
        output outstanding_o, err_o
    );

    modport master (
        output track_valid_i, track_coproc_i, track_id_i,
        input  track_ready_o,
        output coproc_result_valid_i, coproc_result_id_i, coproc_result_data_i,
        output coproc_result_rd_i, coproc_result_we_i, coproc_result_exc_i, coproc_result_exccode_i,
        input  coproc_result_ready_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o,
        input  result_we_o, result_exc_o, result_exccode_o,
        output result_ready_i,
        input  outstanding_o, err_o
    );
endinterface

// File: rtl/xif_result_sequencer.sv
// Merges N_COPROC CV-X-IF result channels into one core result channel in issue order,
// using an in-order FIFO of {coprocessor index, instruction id} filled by the issue dispatcher.
module xif_result_sequencer #(
    parameter int N_COPROC    = 2,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    xif_result_sequencer_if.slave bus
);
    localparam int IDX_W = (N_COPROC > 1) ? $clog2(N_COPROC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0]      fifo_coproc [DEPTH];
    logic [X_ID_WIDTH-1:0] fifo_id     [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [1:0]            err;

    logic                  not_empty;
    logic                  coproc_ok;
    logic                  push;
    logic                  push_bad;
    logic                  pop;
    logic                  id_bad;
    logic                  head_valid;
    logic [IDX_W-1:0]      head_coproc;
    logic [X_ID_WIDTH-1:0] head_id;
    logic [X_ID_WIDTH-1:0] head_result_id;

    assign not_empty     = (count != '0);
    assign head_coproc   = fifo_coproc[rd_ptr];
    assign head_id       = fifo_id[rd_ptr];

    // No pop bypass when full: track_ready depends on registered state only.
    assign bus.track_ready_o = (count < CNT_W'(DEPTH));
    assign coproc_ok         = ({1'b0, bus.track_coproc_i} < (IDX_W + 1)'(N_COPROC));
    assign push              = bus.track_valid_i && bus.track_ready_o && coproc_ok;
    assign push_bad          = bus.track_valid_i && !(bus.track_ready_o && coproc_ok);

    assign head_valid     = not_empty && bus.coproc_result_valid_i[head_coproc];
    assign head_result_id = bus.coproc_result_id_i[int'(head_coproc)*X_ID_WIDTH +: X_ID_WIDTH];
    assign pop            = head_valid && bus.result_ready_i;
    assign id_bad         = pop && (head_result_id != head_id);

    // Only the FIFO head is granted; payload is forced to zero whenever valid is low.
    always_comb begin
        bus.result_valid_o        = head_valid;
        bus.coproc_result_ready_o = '0;
        bus.result_id_o           = '0;
        bus.result_data_o         = '0;
        bus.result_rd_o           = '0;
        bus.result_we_o           = 1'b0;
        bus.result_exc_o          = 1'b0;
        bus.result_exccode_o      = '0;
        if (not_empty) begin
            bus.coproc_result_ready_o[head_coproc] = bus.result_ready_i;
        end
        if (head_valid) begin
            bus.result_id_o      = head_result_id;
            bus.result_data_o    = bus.coproc_result_data_i[int'(head_coproc)*X_RFW_WIDTH +: X_RFW_WIDTH];
            bus.result_rd_o      = bus.coproc_result_rd_i[int'(head_coproc)*5 +: 5];
            bus.result_we_o      = bus.coproc_result_we_i[head_coproc];
            bus.result_exc_o     = bus.coproc_result_exc_i[head_coproc];
            bus.result_exccode_o = bus.coproc_result_exccode_i[int'(head_coproc)*6 +: 6];
        end
    end

    // Entry storage needs no reset: it is only read while count > 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_coproc[wr_ptr] <= bus.track_coproc_i;
            fifo_id[wr_ptr]     <= bus.track_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            err <= err | {push_bad, id_bad};
        end
    end

    assign bus.outstanding_o = count;
    assign bus.err_o         = err;
endmodule

// File: doc/xif_result_sequencer.md
Name: xif_result_sequencer

Overview:
- Result-path counterpart of the tile's Xif issue dispatcher. It merges the CV-X-IF result channels of N_COPROC coprocessors into the single result channel of the cv32e40x core.
- Results must reach the core in issue order. The block therefore records which coprocessor owns each issued writeback instruction in a small in-order FIFO.
- Only the coprocessor at the FIFO head is granted the core result channel.
- Sits between the coprocessor result ports and the core result port, next to the issue dispatcher, which supplies the tracking pushes.

Parameters:
- N_COPROC, 2, number of coprocessor result channels.
- X_ID_WIDTH, 4, CV-X-IF instruction id width.
- X_RFW_WIDTH, 32, result data width.
- DEPTH, 4, tracking FIFO entries. Must be a power of two, >=2.
- IDX_W, $clog2(N_COPROC) (min 1), derived; coprocessor index width.
- CNT_W, $clog2(DEPTH+1), derived; occupancy width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- track_valid_i  in  1  issue handshake completed with accept=1 and writeback=1.
- track_coproc_i  in  IDX_W  index of the coprocessor that accepted the instruction.
- track_id_i  in  X_ID_WIDTH  id of the issued instruction.
- track_ready_o  out  1  FIFO can take an entry.
- coproc_result_valid_i  in  N_COPROC  per-coprocessor result_valid.
- coproc_result_ready_o  out  N_COPROC  per-coprocessor result_ready.
- coproc_result_id_i  in  N_COPROC*X_ID_WIDTH  per-coprocessor result id.
- coproc_result_data_i  in  N_COPROC*X_RFW_WIDTH  per-coprocessor result data.
- coproc_result_rd_i  in  N_COPROC*5  per-coprocessor destination register.
- coproc_result_we_i  in  N_COPROC  per-coprocessor write enable.
- coproc_result_exc_i  in  N_COPROC  per-coprocessor exception flag.
- coproc_result_exccode_i  in  N_COPROC*6  per-coprocessor exception code.
- result_valid_o  out  1  to core.
- result_ready_i  in  1  from core.
- result_id_o  out  X_ID_WIDTH  to core.
- result_data_o  out  X_RFW_WIDTH  to core.
- result_rd_o  out  5  to core.
- result_we_o  out  1  to core.
- result_exc_o  out  1  to core.
- result_exccode_o  out  6  to core.
- outstanding_o  out  CNT_W  current FIFO occupancy.
- err_o  out  2  sticky: [0] id mismatch, [1] tracking protocol violation.

Behaviour:
- Reset (async, rst_ni low):
  - wr/rd pointers=0, count=0, err_o=0.
  - Combinationally this gives: track_ready_o=1, result_valid_o=0, all coproc_result_ready_o=0, all result_* data outputs=0, outstanding_o=0.
  - Reset mid-operation discards every tracked entry. A result pending at the core is dropped without a handshake.
- FIFO entry = {coproc idx, id}.
  - track_ready_o = (count<DEPTH). There is no full-with-pop bypass, so there is no combinational path from result_ready_i to track_ready_o.
  - Push when track_valid_i && track_ready_o: entry written at wr_ptr, wr_ptr+1 modulo DEPTH (natural wrap).
- Head grant (combinational, count>0, head coproc h):
  - result_valid_o = coproc_result_valid_i[h].
  - coproc_result_ready_o[h] = result_ready_i; all other coproc_result_ready_o = 0.
  - result_id/data/rd/we/exc/exccode_o = coprocessor h's fields.
  - When result_valid_o=0, all result_* data outputs = 0.
- Empty (count=0): result_valid_o=0, all coproc_result_ready_o=0, result_* data outputs=0. Coprocessors presenting valid results stall.
- Pop on result_valid_o && result_ready_i: rd_ptr+1 modulo DEPTH.
  - Same cycle, if coproc_result_id_i[h] != head id, set err_o[0]. The result is still forwarded and popped.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - outstanding_o = count.
- Latency: an entry pushed in cycle t can be granted from cycle t+1. The result path is zero-latency combinational pass-through, so the core sees a result in the same cycle the head coprocessor presents it.
- A valid result from a non-head coprocessor is held off (ready=0) until its entry reaches the head. Its payload must stay stable per CV-X-IF.
- Protocol violations set err_o[1]; in both cases the FIFO is unchanged:
  - track_valid_i while track_ready_o=0 (push ignored).
  - track_coproc_i >= N_COPROC (push ignored).
- err_o bits are sticky until reset.

Test Plan:
- Reset, then idle -> track_ready_o=1, outstanding_o=0, result_valid_o=0, coproc_result_ready_o=2'b00, err_o=0.
- Push {c1,id3} then {c0,id4}. Coproc0 asserts valid id4 first, coproc1 asserts id3 two cycles later, result_ready_i=1 -> core sees id3 first, then id4; coproc_result_ready_o[0] stays 0 until id3 pops; outstanding_o goes 2->1->0.
- Push 4 entries with no results -> track_ready_o=0. A 5th track_valid_i is dropped and sets err_o[1]=1; outstanding_o stays 4.
- Count=2, same cycle push and pop -> outstanding_o stays 2. Repeat 10 times to wrap the pointers; all ids emerge in order.
- Head {c0,id5}, coproc0 returns id6 with data 0xDEADBEEF -> result_data_o=0xDEADBEEF, result_id_o=6, pop occurs, err_o[0]=1.
- Count=3 with coproc0 valid pending, assert rst_ni=0 -> next cycle outstanding_o=0, result_valid_o=0, coproc_result_ready_o=0, err_o=0.
